// File: rtl/arm_pkg.sv
// Shared ARM core definitions: condition codes, NZCV bit positions, E-stage control bundle.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] COND_BUBBLE = COND_AL;

    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic [1:0] flagwrite;
        logic [3:0] cond;
    } ectrl_t;

    localparam ectrl_t ECTRL_BUBBLE = '{
        pcsrc:     1'b0,
        regwrite:  1'b0,
        memwrite:  1'b0,
        memtoreg:  1'b0,
        flagwrite: 2'b00,
        cond:      COND_BUBBLE
    };

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator: Cond + NZCV -> pass/fail.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// E-stage conditional execution: E control register, NZCV register, gated side effects.
// Optional failed-condition counter enabled by defining COND_EXEC_SQUASH_CNT_EN.
module cond_exec_unit
    import arm_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushE,
    input  logic             StallE,
    input  logic             PCSrcD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemtoRegD,
    input  logic [1:0]       FlagWriteD,
    input  logic [3:0]       CondD,
    input  logic [3:0]       ALUFlags,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemtoRegE,
    output logic             CondExE,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCount
);

    ectrl_t     e_q, e_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;

    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = ECTRL_BUBBLE;
        end else if (!StallE) begin
            e_d.pcsrc     = PCSrcD;
            e_d.regwrite  = RegWriteD;
            e_d.memwrite  = MemWriteD;
            e_d.memtoreg  = MemtoRegD;
            e_d.flagwrite = FlagWriteD;
            e_d.cond      = CondD;
        end
    end

    cond_check u_cond_check (
        .Cond   (e_q.cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // Held instructions still write flags: the hazard unit never stalls a flag-setter.
    always_comb begin
        flags_d = flags_q;
        if (e_q.flagwrite[1] && cond_ex) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (e_q.flagwrite[0] && cond_ex) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q     <= ECTRL_BUBBLE;
            flags_q <= FLAGS_RST;
        end else begin
            e_q     <= e_d;
            flags_q <= flags_d;
        end
    end

    assign PCSrcE    = e_q.pcsrc    & cond_ex;
    assign RegWriteE = e_q.regwrite & cond_ex;
    assign MemWriteE = e_q.memwrite & cond_ex;
    assign MemtoRegE = e_q.memtoreg;
    assign CondExE   = cond_ex;
    assign Flags     = flags_q;

`ifdef COND_EXEC_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             e_bubble;

    assign e_bubble = (e_q == ECTRL_BUBBLE);

    always_comb begin
        squash_d = squash_q;
        if (!StallE && !FlushE && !e_bubble && !cond_ex && (squash_q != '1)) begin
            squash_d = squash_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            squash_q <= '0;
        end else begin
            squash_q <= squash_d;
        end
    end

    assign SquashCount = squash_q;
`else
    assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed self-checking bench for cond_exec_unit (counter checks follow COND_EXEC_SQUASH_CNT_EN).
module tb_cond_exec_unit;

    localparam int unsigned CNT_W     = 4;
    localparam logic [3:0]  FLAGS_RST = 4'b0110;

    logic             clk;
    logic             reset;
    logic             FlushE;
    logic             StallE;
    logic             PCSrcD;
    logic             RegWriteD;
    logic             MemWriteD;
    logic             MemtoRegD;
    logic [1:0]       FlagWriteD;
    logic [3:0]       CondD;
    logic [3:0]       ALUFlags;
    logic             PCSrcE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             MemtoRegE;
    logic             CondExE;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] SquashCount;

    int unsigned checks = 0;
    int unsigned errors = 0;

    cond_exec_unit #(
        .CNT_W     (CNT_W),
        .FLAGS_RST (FLAGS_RST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .FlushE      (FlushE),
        .StallE      (StallE),
        .PCSrcD      (PCSrcD),
        .RegWriteD   (RegWriteD),
        .MemWriteD   (MemWriteD),
        .MemtoRegD   (MemtoRegD),
        .FlagWriteD  (FlagWriteD),
        .CondD       (CondD),
        .ALUFlags    (ALUFlags),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .MemtoRegE   (MemtoRegE),
        .CondExE     (CondExE),
        .Flags       (Flags),
        .SquashCount (SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic pcs, input logic rw, input logic mw, input logic m2r,
                         input logic [1:0] fw, input logic [3:0] cond);
        PCSrcD     = pcs;
        RegWriteD  = rw;
        MemWriteD  = mw;
        MemtoRegD  = m2r;
        FlagWriteD = fw;
        CondD      = cond;
    endtask

    task automatic set_bubble();
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1110);
    endtask

    // AL flag-setter enters E, ALU presents f, then a bubble follows.
    task automatic load_flags(input logic [3:0] f);
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1110);
        tick();
        ALUFlags = f;
        set_bubble();
        tick();
        ALUFlags = 4'b0000;
    endtask

    // {flags, cond, expected CondEx}, hand-evaluated
    localparam int unsigned NVEC = 30;
    logic [8:0] cond_vec [NVEC] = '{
        {4'b0100, 4'b0000, 1'b1}, {4'b0100, 4'b0001, 1'b0},
        {4'b0100, 4'b1000, 1'b0}, {4'b0100, 4'b1001, 1'b1},
        {4'b0010, 4'b0010, 1'b1}, {4'b0010, 4'b0011, 1'b0},
        {4'b0010, 4'b1000, 1'b1}, {4'b0010, 4'b1001, 1'b0},
        {4'b1000, 4'b0100, 1'b1}, {4'b1000, 4'b0101, 1'b0},
        {4'b1000, 4'b1010, 1'b0}, {4'b1000, 4'b1011, 1'b1},
        {4'b1000, 4'b1100, 1'b0}, {4'b1000, 4'b1101, 1'b1},
        {4'b0001, 4'b0110, 1'b1}, {4'b0001, 4'b0111, 1'b0},
        {4'b0001, 4'b1010, 1'b0}, {4'b0001, 4'b1011, 1'b1},
        {4'b1001, 4'b1010, 1'b1}, {4'b1001, 4'b1011, 1'b0},
        {4'b1001, 4'b1100, 1'b1}, {4'b1001, 4'b1101, 1'b0},
        {4'b1101, 4'b1100, 1'b0}, {4'b1101, 4'b1101, 1'b1},
        {4'b0000, 4'b1110, 1'b1}, {4'b0000, 4'b1111, 1'b0},
        {4'b0000, 4'b0101, 1'b1}, {4'b0000, 4'b1100, 1'b1},
        {4'b0000, 4'b0000, 1'b0}, {4'b1111, 4'b0001, 1'b0}
    };

    logic [CNT_W-1:0] exp_cnt;

    initial begin
        reset    = 1'b1;
        FlushE   = 1'b0;
        StallE   = 1'b0;
        ALUFlags = 4'b0000;
        set_bubble();
        tick();
        tick();
        reset = 1'b0;

        check("rst_pcsrc",    16'(PCSrcE),      16'h0);
        check("rst_regwrite", 16'(RegWriteE),   16'h0);
        check("rst_memwrite", 16'(MemWriteE),   16'h0);
        check("rst_memtoreg", 16'(MemtoRegE),   16'h0);
        check("rst_condex",   16'(CondExE),     16'h1);
        check("rst_flags",    16'(Flags),       16'h6);
        check("rst_squash",   16'(SquashCount), 16'h0);

        // CMP then BEQ back to back
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1110);
        tick();
        ALUFlags = 4'b0100;
        set_d(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        tick();
        ALUFlags = 4'b0000;
        check("cmp_flags",  16'(Flags),   16'h4);
        check("beq_pcsrc",  16'(PCSrcE),  16'h1);
        check("beq_condex", 16'(CondExE), 16'h1);

        // Failed NE annuls writes, MemtoReg passes through
        set_d(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 4'b0001);
        tick();
        check("ne_regwrite", 16'(RegWriteE), 16'h0);
        check("ne_memwrite", 16'(MemWriteE), 16'h0);
        check("ne_pcsrc",    16'(PCSrcE),    16'h0);
        check("ne_condex",   16'(CondExE),   16'h0);
        check("ne_memtoreg", 16'(MemtoRegE), 16'h1);

        // Passing EQ lets the same writes through
        set_d(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000);
        tick();
        check("eq_regwrite", 16'(RegWriteE), 16'h1);
        check("eq_memwrite", 16'(MemWriteE), 16'h1);
        check("eq_memtoreg", 16'(MemtoRegE), 16'h0);

        // Partial flag write: N,Z only
        load_flags(4'b0011);
        check("pre_partial", 16'(Flags), 16'h3);
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b1110);
        tick();
        ALUFlags = 4'b1000;
        set_bubble();
        tick();
        check("partial_nz", 16'(Flags), 16'hB);

        // C,V only
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b1110);
        tick();
        ALUFlags = 4'b0100;
        set_bubble();
        tick();
        check("partial_cv", 16'(Flags), 16'h8);

        // Flag write blocked by failed condition (EQ with Z=0)
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000);
        tick();
        ALUFlags = 4'b0111;
        set_bubble();
        tick();
        check("fw_annulled", 16'(Flags), 16'h8);

        // Condition table, PCSrcE gated by each result
        for (int i = 0; i < NVEC; i++) begin
            logic [8:0] v;
            v = cond_vec[i];
            load_flags(v[8:5]);
            set_d(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, v[4:1]);
            tick();
            check($sformatf("cond_%h_fl_%h", v[4:1], v[8:5]), 16'(CondExE), 16'(v[0]));
            check($sformatf("pcs_%h_fl_%h", v[4:1], v[8:5]), 16'(PCSrcE), 16'(v[0]));
        end

        // NV never passes
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1111);
            tick();
            check($sformatf("nv_fl_%h", f), 16'(CondExE), 16'h0);
        end

        // Flush wins over stall
        set_d(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 4'b1110);
        tick();
        check("pre_flush_rw", 16'(RegWriteE), 16'h1);
        FlushE = 1'b1;
        StallE = 1'b1;
        set_d(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'b0000);
        tick();
        FlushE = 1'b0;
        StallE = 1'b0;
        check("flush_pcsrc",    16'(PCSrcE),    16'h0);
        check("flush_regwrite", 16'(RegWriteE), 16'h0);
        check("flush_memwrite", 16'(MemWriteE), 16'h0);
        check("flush_memtoreg", 16'(MemtoRegE), 16'h0);
        check("flush_condex",   16'(CondExE),   16'h1);

        // Stall holds E
        set_d(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b1110);
        tick();
        StallE = 1'b1;
        set_bubble();
        tick();
        check("stall_regwrite", 16'(RegWriteE), 16'h1);
        check("stall_memtoreg", 16'(MemtoRegE), 16'h1);
        StallE = 1'b0;
        tick();
        check("unstall_regwrite", 16'(RegWriteE), 16'h0);

        // Held flag-setter still updates flags
        load_flags(4'b0000);
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1110);
        tick();
        StallE   = 1'b1;
        ALUFlags = 4'b1100;
        set_bubble();
        tick();
        check("stall_flags", 16'(Flags), 16'hC);
        StallE   = 1'b0;
        ALUFlags = 4'b0000;
        tick();

        // Reset mid-stream
        load_flags(4'b1011);
        set_d(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'b1110);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_flags",    16'(Flags),     16'h6);
        check("mid_rst_regwrite", 16'(RegWriteE), 16'h0);
        check("mid_rst_condex",   16'(CondExE),   16'h1);

        // Squash counter: NV instructions stream through E
        exp_cnt = '0;
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1111);
        tick();
        for (int i = 0; i < 3; i++) tick();
`ifdef COND_EXEC_SQUASH_CNT_EN
        exp_cnt = 4'd3;
`endif
        check("squash_3", 16'(SquashCount), 16'(exp_cnt));
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        StallE = 1'b0;
        check("squash_stalled", 16'(SquashCount), 16'(exp_cnt));
        tick();
`ifdef COND_EXEC_SQUASH_CNT_EN
        exp_cnt = 4'd4;
`endif
        check("squash_4", 16'(SquashCount), 16'(exp_cnt));
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        tick();
        check("squash_flush", 16'(SquashCount), 16'(exp_cnt));
        for (int i = 0; i < 20; i++) tick();
`ifdef COND_EXEC_SQUASH_CNT_EN
        exp_cnt = 4'hF;
`endif
        check("squash_sat", 16'(SquashCount), 16'(exp_cnt));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("squash_rst", 16'(SquashCount), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
